// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 W-bit registered mux between N requesters.
// A grant captures the winner's data; valid/ready hands it downstream and acks the winner.
module rr_mux_arbiter #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   din,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic [W-1:0]     gdata;
  logic             xfer;

  // Search starts at ptr; the SEL_W-bit add wraps modulo N since N is a power of two.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) gdata = din[i*W +: W];
    end
  end

  assign xfer       = (state_q == HOLD) && dout_ready;
  assign dout_valid = (state_q == HOLD);
  assign busy       = dout_valid;

  always_comb begin
    ack = '0;
    if (xfer) ack[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = HOLD;
      HOLD:    if (dout_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      sel   <= '0;
      ptr_q <= '0;
    end else begin
      if (state_q == IDLE && found) begin
        dout <= gdata;
        sel  <= grant;
      end
      if (xfer) ptr_q <= sel + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model.
module tb_rr_mux_arbiter;
  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0] ack;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [2:0]   sel;
  logic         busy;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic       m_valid;
  logic [7:0] m_dout;
  logic [2:0] m_sel;
  int         m_ptr;

  rr_mux_arbiter #(.N(N), .W(W), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_ack();
    return (m_valid && dout_ready) ? 8'(1 << m_sel) : 8'h00;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_dout = 8'h00; m_sel = 3'd0; m_ptr = 0;
  endtask

  // Advance the model by one edge using the current inputs, then step the clock.
  task automatic tick();
    if (m_valid) begin
      if (dout_ready) begin
        m_valid = 1'b0;
        m_ptr   = (int'(m_sel) + 1) % N;
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_valid && req[j]) begin
          m_valid = 1'b1;
          m_sel   = 3'(j);
          m_dout  = din[j*W +: W];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; dout_ready = 1'b0; rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if ({dout_valid, busy, dout, sel, ack} !== 21'd0)
      $display("FAIL reset_state: got v=%b d=%h s=%0d a=%h exp all zero", dout_valid, dout, sel, ack);
    else passes++;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({dout_valid, busy, dout, sel, ack} !== 21'd0)
        $display("FAIL idle_no_req: got v=%b d=%h s=%0d a=%h exp all zero", dout_valid, dout, sel, ack);
      else passes++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h01; din[0 +: W] = 8'hA5; dout_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (c % 2 == 0) begin
        if ({dout_valid, dout, sel, ack} !== {1'b1, 8'hA5, 3'd0, 8'h01})
          $display("FAIL single_grant: got v=%b d=%h s=%0d a=%h exp v=1 d=a5 s=0 a=01", dout_valid, dout, sel, ack);
        else passes++;
      end else begin
        if ({dout_valid, ack} !== {1'b0, 8'h00})
          $display("FAIL single_gap: got v=%b a=%h exp v=0 a=00", dout_valid, ack);
        else passes++;
      end
    end
    req = '0;
  endtask

  task automatic test_all_req();
    do_reset();
    for (int i = 0; i < N; i++) din[i*W +: W] = 8'(8'h10 + i);
    req = 8'hFF; dout_ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      tick();
      checks++;
      if ({dout_valid, sel, dout, ack} !== {1'b1, 3'(g % N), 8'(8'h10 + g % N), 8'(1 << (g % N))})
        $display("FAIL all_req_seq%0d: got s=%0d d=%h a=%h exp s=%0d d=%h a=%h",
                 g, sel, dout, ack, g % N, 8'h10 + g % N, 8'(1 << (g % N)));
      else passes++;
      tick();
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    logic [2:0] exp_s [5];
    logic [7:0] reqs  [5];
    exp_s = '{3'd4, 3'd7, 3'd4, 3'd7, 3'd0};
    reqs  = '{8'h10, 8'h90, 8'h90, 8'h90, 8'h81};
    do_reset();
    dout_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req = reqs[t];
      tick();
      checks++;
      if ({dout_valid, sel, ack} !== {1'b1, exp_s[t], 8'(1 << exp_s[t])})
        $display("FAIL ptr_wrap%0d: got v=%b s=%0d a=%h exp s=%0d", t, dout_valid, sel, ack, exp_s[t]);
      else passes++;
      tick();
    end
    req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    din[2*W +: W] = 8'h3C; req = 8'h04; dout_ready = 1'b0;
    tick();
    din[2*W +: W] = 8'h00;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({dout_valid, dout, sel, ack} !== {1'b1, 8'h3C, 3'd2, 8'h00})
        $display("FAIL stall_hold%0d: got v=%b d=%h s=%0d a=%h exp v=1 d=3c s=2 a=00", c, dout_valid, dout, sel, ack);
      else passes++;
      tick();
    end
    dout_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h04) $display("FAIL stall_release_ack: got %h exp 04", ack);
    else passes++;
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    din[1*W +: W] = 8'h77; req = 8'h02; dout_ready = 1'b0;
    tick();
    dout_ready = 1'b1;
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if ({dout_valid, dout, ack} !== {1'b0, 8'h00, 8'h00})
      $display("FAIL reset_mid: got v=%b d=%h a=%h exp v=0 d=00 a=00", dout_valid, dout, ack);
    else passes++;
    #2;
    rst_n = 1'b1; req = 8'h08; din[3*W +: W] = 8'h5A;
    tick();
    checks++;
    if ({dout_valid, sel, dout} !== {1'b1, 3'd3, 8'h5A})
      $display("FAIL reset_mid_regrant: got v=%b s=%0d d=%h exp v=1 s=3 d=5a", dout_valid, sel, dout);
    else passes++;
    tick();
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      din        = {$urandom, $urandom};
      dout_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if ({dout_valid, busy, dout, sel, ack} !== {m_valid, m_valid, m_dout, m_sel, exp_ack()})
        $display("FAIL random_c%0d: got v=%b d=%h s=%0d a=%h exp v=%b d=%h s=%0d a=%h",
                 c, dout_valid, dout, sel, ack, m_valid, m_dout, m_sel, exp_ack());
      else passes++;
      tick();
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_ptr_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one W-bit, N-way output multiplexer between N requesters.
- Each cycle in IDLE it picks one pending requester and captures that requester's data into an output register.
- It presents the captured word downstream with a valid/ready handshake and returns a one-cycle ack to the winning requester.
- Sits in front of the registered 8:1 byte mux datapath and replaces free-running select control with fair, flow-controlled selection.

Parameters:
- N, 8, number of requesters (power of two, 2..16).
- W, 8, data width per requester.
- SEL_W, 3, width of the select index; must equal log2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; bit i high means din slice i holds valid data.
- din  input  N*W  flattened requester data; requester i occupies bits [i*W +: W].
- ack  output  N  one-hot, one-cycle pulse; the transfer for requester i completed this cycle.
- dout  output  W  registered selected data.
- dout_valid  output  1  dout holds a word awaiting acceptance.
- dout_ready  input  1  downstream accepts dout this cycle when high together with dout_valid.
- sel  output  SEL_W  index of the requester whose data is in dout (registered).
- busy  output  1  high while in HOLD (equals dout_valid).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; dout=0; dout_valid=0; sel=0; round-robin pointer ptr=0.
  - ack=0 combinationally while reset is held.
- FSM has two states: IDLE and HOLD.
- IDLE:
  - If req==0, remain in IDLE; all outputs hold, dout_valid=0.
  - Else grant the first set bit of req searching ptr, ptr+1, ... , ptr+N-1 (mod N).
  - Grant winner g at this edge: dout<=din[g], sel<=g, dout_valid<=1, state<=HOLD.
  - Latency: req sampled high at edge k gives dout_valid high after edge k, i.e. visible in cycle k+1.
- HOLD:
  - dout, sel and dout_valid are stable until dout_valid&dout_ready.
  - On a cycle with dout_ready high:
    - ack[sel]=1 combinationally in that same cycle (ack = dout_valid & dout_ready decoded by sel).
    - At the edge: dout_valid<=0, ptr<=(sel+1) mod N, state<=IDLE.
  - dout_ready low: stay in HOLD indefinitely; no ack.
- Throughput: at most one transfer per 2 cycles, because IDLE is always one cycle between grants; no back-to-back bypass.
- Requester rules:
  - A requester holds req and its din slice stable until it sees its ack.
  - It may drop req the cycle after ack.
  - din changes after the grant edge do not affect dout (captured copy).
  - If a requester drops req while granted (protocol violation), the transfer still completes with the captured data and the ack is still issued.
- Fairness:
  - ptr only advances on a completed transfer.
  - A requester that keeps req high is served within N grants.
  - A single active requester is served every 2 cycles.
- ptr wrap: sel=N-1 accepted gives ptr=0.
- Simultaneous events:
  - New req bits arriving during HOLD are ignored until the next IDLE cycle.
  - The ack cycle and a new request from the same requester do not conflict, because that requester is deprioritised by ptr.
- Reset mid-transfer:
  - The pending word is discarded with no ack.
  - ptr returns to 0.
- ack is never asserted outside HOLD and is always one-hot or zero.

Test Plan:
1. Reset then req=8'h00 for 10 cycles -> dout_valid=0, ack=0, sel=0, dout=8'h00 throughout.
2. req=8'h01, din[0]=8'hA5, dout_ready=1 -> dout_valid high one cycle later with dout=8'hA5, sel=0; ack=8'h01 that same cycle; repeat shows one grant per 2 cycles.
3. req=8'hFF held, din[i]=8'h10+i, dout_ready=1 -> sel sequence 0,1,2,...,7,0; dout=8'h10,8'h11,...,8'h17,8'h10; each ack one-hot matching sel.
4. req=8'h90 (requesters 4 and 7) with ptr=5 after a prior grant of 4 -> requester 7 granted first, then 4; ptr wraps to 0 after sel=7 accepted.
5. Grant requester 2 with dout_ready=0 for 6 cycles while din[2] changes to 8'h00 -> dout held at original 8'h3C, no ack; ack=8'h04 in the cycle dout_ready rises.
6. rst_n pulled low in HOLD with dout_valid=1 -> dout_valid=0 and dout=0 immediately, no ack; after release with req=8'h08 -> sel=3 (ptr restarted at 0).
